// File: rtl/peak_lag_streamer.sv
// Buffers packed cross-correlation peak indices and streams each word out as
// NUM_XCORRS signed lag beats (index - MAX_LAGS), with SOP/EOP framing and drop accounting.
module peak_lag_streamer #(
  parameter int MAX_LAGS       = 11,
  parameter int BITS_PER_XCORR = 6,
  parameter int NUM_XCORRS     = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_XCORRS*BITS_PER_XCORR-1:0] dataIn,
  input  logic                                 dataInValid,
  input  logic                                 clearStatus,
  output logic [7:0]                           dataOut,
  output logic                                 dataOutValid,
  input  logic                                 dataOutReady,
  output logic                                 dataOutSop,
  output logic                                 dataOutEop,
  output logic                                 overflow,
  output logic [15:0]                          dropCount
);

  localparam int W     = NUM_XCORRS * BITS_PER_XCORR;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int KW    = (NUM_XCORRS > 1) ? $clog2(NUM_XCORRS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;

  logic fifo_empty, fifo_full, handshake, last_beat, pop, push, drop;
  logic [BITS_PER_XCORR-1:0] idx_arr [NUM_XCORRS];
  logic [31:0] idx_ext;
  logic [7:0]  lag;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign handshake  = (state_q == SEND) && dataOutReady;
  assign last_beat  = (k_q == KW'(NUM_XCORRS - 1));
  // Popping on the final handshake keeps consecutive packets bubble-free.
  assign pop  = !fifo_empty && ((state_q == IDLE) || (handshake && last_beat));
  assign push = dataInValid && (!fifo_full || pop);
  assign drop = dataInValid && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= dataIn;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    if (pop) hold_d = mem[rd_ptr_q];
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = SEND;
          k_d     = '0;
        end
      end
      SEND: begin
        if (handshake) begin
          if (last_beat) begin
            k_d = '0;
            if (!pop) state_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d   = clearStatus ? 1'b0 : overflow_q;
    drop_count_d = clearStatus ? 16'd0 : drop_count_q;
    // A drop in the same cycle as a clear counts against the freshly cleared state.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != 16'hFFFF) drop_count_d = drop_count_d + 16'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_XCORRS; gi++) begin : g_idx
      assign idx_arr[gi] = hold_q[gi*BITS_PER_XCORR +: BITS_PER_XCORR];
    end
  endgenerate

  always_comb begin
    idx_ext = 32'(idx_arr[k_q]);
    if (idx_ext > 32'(2 * MAX_LAGS)) lag = 8'h80;
    else                             lag = 8'(idx_ext - 32'(MAX_LAGS));
  end

  assign dataOutValid = (state_q == SEND);
  assign dataOut      = (state_q == SEND) ? lag : 8'h00;
  assign dataOutSop   = (state_q == SEND) && (k_q == '0);
  assign dataOutEop   = (state_q == SEND) && last_beat;
  assign overflow     = overflow_q;
  assign dropCount    = drop_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      k_q          <= '0;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      k_q          <= k_d;
      hold_q       <= hold_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule
